// File: rtl/br_flow_demux_select_stable.sv
// Stable ready-valid demultiplexer: one push stream fanned out to NumFlows
// registered pop lanes, steered by a per-beat select index.
module br_flow_demux_select_stable #(
  parameter int NumFlows = 2,
  parameter int Width = 1,
  parameter bit RegisterPopReady = 1'b0,
  parameter bit EnableCoverPushBackpressure = 1'b1,
  parameter bit EnableAssertPushDataKnown = 1'b1,
  parameter bit EnableAssertFinalNotValid = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               push_ready,
  input  logic                               push_valid,
  input  logic [Width-1:0]                   push_data,
  input  logic [$clog2(NumFlows)-1:0]        push_select,
  input  logic [NumFlows-1:0]                pop_ready,
  output logic [NumFlows-1:0]                pop_valid,
  output logic [NumFlows-1:0][Width-1:0]     pop_data
);

  localparam int SelW = $clog2(NumFlows);

  if (NumFlows < 2) begin : g_bad_num_flows
    $error("NumFlows must be >= 2");
  end
  if (Width < 1) begin : g_bad_width
    $error("Width must be >= 1");
  end

  logic [NumFlows-1:0] w_lane_ready;
  logic [NumFlows-1:0] w_push_en;

  // Out-of-range selects never match a lane, so push_ready stays low for them.
  always_comb begin
    push_ready = 1'b0;
    for (int unsigned i = 0; i < NumFlows; i++) begin
      if (!rst && (push_select == SelW'(i))) begin
        push_ready = w_lane_ready[i];
      end
    end
  end

  for (genvar i = 0; i < NumFlows; i++) begin : g_lane
    assign w_push_en[i] = push_valid && push_ready && (push_select == SelW'(i));

    if (RegisterPopReady == 1'b0) begin : g_fwd
      logic             r_head_valid;
      logic [Width-1:0] r_head_data;

      assign w_lane_ready[i] = !r_head_valid || pop_ready[i];
      assign pop_valid[i]    = r_head_valid;
      assign pop_data[i]     = r_head_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_head_valid <= 1'b0;
          r_head_data  <= '0;
        end else if (w_push_en[i]) begin
          r_head_valid <= 1'b1;
          r_head_data  <= push_data;
        end else if (pop_ready[i]) begin
          r_head_valid <= 1'b0;
        end
      end
    end else begin : g_skid
      logic             r_head_valid;
      logic [Width-1:0] r_head_data;
      logic             r_skid_valid;
      logic [Width-1:0] r_skid_data;

      assign w_lane_ready[i] = !r_skid_valid;
      assign pop_valid[i]    = r_head_valid;
      assign pop_data[i]     = r_head_data;

      // A push only lands while the skid is empty, so a draining skid never collides with it.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_head_valid <= 1'b0;
          r_head_data  <= '0;
          r_skid_valid <= 1'b0;
          r_skid_data  <= '0;
        end else if (!r_head_valid || pop_ready[i]) begin
          if (r_skid_valid) begin
            r_head_valid <= 1'b1;
            r_head_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
          end else begin
            r_head_valid <= w_push_en[i];
            if (w_push_en[i]) begin
              r_head_data <= push_data;
            end
          end
        end else if (w_push_en[i]) begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= push_data;
        end
      end
    end

    assert property (@(posedge clk) disable iff (rst)
      (pop_valid[i] && !pop_ready[i]) |=> (pop_valid[i] && $stable(pop_data[i])));
  end

  assert property (@(posedge clk) disable iff (rst)
    push_valid |-> (32'(push_select) < NumFlows));

  assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=>
      (push_valid && $stable(push_data) && $stable(push_select)));

  if (EnableCoverPushBackpressure) begin : g_cover_bp
    cover property (@(posedge clk) disable iff (rst) (push_valid && !push_ready));
  end else begin : g_assert_no_bp
    assert property (@(posedge clk) disable iff (rst) !(push_valid && !push_ready));
  end

  if (EnableAssertPushDataKnown) begin : g_known
    assert property (@(posedge clk) disable iff (rst)
      push_valid |-> !$isunknown({push_data, push_select}));
  end

  if (EnableAssertFinalNotValid) begin : g_final
    final begin
      assert (!push_valid && (pop_valid == '0));
    end
  end

endmodule

// File: tb/tb_br_flow_demux_select_stable.sv
// Directed bench for br_flow_demux_select_stable: forward and skid lane builds
// share one step sequence, with a per-lane scoreboard checking popped data.
module tb_br_flow_demux_select_stable;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i [2];
  logic             pv    [2];
  logic [7:0]       pd    [2];
  logic [1:0]       ps    [2];
  logic [3:0]       prdy  [2];
  logic             pr_o  [2];
  logic [3:0]       popv  [2];
  logic [3:0][7:0]  popd  [2];

  logic             rst2;
  logic             pv2;
  logic [7:0]       pd2;
  logic [1:0]       ps2;
  logic [2:0]       prdy2;
  logic             pr2;
  logic [2:0]       popv2;
  logic [2:0][7:0]  popd2;

  int n_checks = 0;
  int n_fail = 0;
  int cur_d = 0;
  int npops [2] = '{0, 0};
  logic [7:0] sb [8][$];

  br_flow_demux_select_stable #(.NumFlows(4), .Width(8), .RegisterPopReady(1'b0)) dut0 (
    .clk(clk), .rst(rst_i[0]), .push_ready(pr_o[0]), .push_valid(pv[0]),
    .push_data(pd[0]), .push_select(ps[0]), .pop_ready(prdy[0]),
    .pop_valid(popv[0]), .pop_data(popd[0])
  );

  br_flow_demux_select_stable #(.NumFlows(4), .Width(8), .RegisterPopReady(1'b1)) dut1 (
    .clk(clk), .rst(rst_i[1]), .push_ready(pr_o[1]), .push_valid(pv[1]),
    .push_data(pd[1]), .push_select(ps[1]), .pop_ready(prdy[1]),
    .pop_valid(popv[1]), .pop_data(popd[1])
  );

  br_flow_demux_select_stable #(.NumFlows(3), .Width(8), .RegisterPopReady(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .push_ready(pr2), .push_valid(pv2),
    .push_data(pd2), .push_select(ps2), .pop_ready(prdy2),
    .pop_valid(popv2), .pop_data(popd2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, cur_d, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push side records accepted beats; pop side retires them in per-lane order.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_i[d]) begin
        for (int l = 0; l < 4; l++) begin
          if (popv[d][l] && prdy[d][l]) begin
            npops[d]++;
            check("pop_sb_nonempty", 32'(sb[d*4+l].size() != 0), 32'd1);
            if (sb[d*4+l].size() != 0) begin
              check("pop_data_order", 32'(popd[d][l]), 32'(sb[d*4+l].pop_front()));
            end
          end
        end
        if (pv[d] && pr_o[d]) begin
          sb[d*4+32'(ps[d])].push_back(pd[d]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1; pv[d] = 1'b0; pd[d] = '0; ps[d] = '0; prdy[d] = '1;
    end
    rst2 = 1'b1; pv2 = 1'b0; pd2 = '0; ps2 = '0; prdy2 = '1;

    for (int d = 0; d < 2; d++) begin
      cur_d = d;

      rst_i[d] = 1'b1; pv[d] = 1'b1; pd[d] = 8'h77; ps[d] = 2'd2;
      for (int c = 0; c < 3; c++) begin
        tick();
        check("rst_push_ready", 32'(pr_o[d]), 32'd0);
        check("rst_pop_valid", 32'(popv[d]), 32'd0);
        check("rst_pop_data", 32'(popd[d]), 32'd0);
      end
      pv[d] = 1'b0;
      tick();
      rst_i[d] = 1'b0;
      tick();
      check("post_rst_pop_valid", 32'(popv[d]), 32'd0);

      pv[d] = 1'b1; pd[d] = 8'hA1; ps[d] = 2'd2;
      check("route_push_ready", 32'(pr_o[d]), 32'd1);
      tick();
      pv[d] = 1'b0;
      check("route_pop_valid", 32'(popv[d]), 32'b0100);
      check("route_pop_data", 32'(popd[d][2]), 32'hA1);
      tick();
      check("route_drain", 32'(popv[d]), 32'd0);

      prdy[d] = 4'b1101; pv[d] = 1'b1; pd[d] = 8'h3C; ps[d] = 2'd1;
      tick();
      pd[d] = 8'h55;
      check("bp_push_ready", 32'(pr_o[d]), 32'(d == 1));
      tick();
      if (d == 1) begin
        pv[d] = 1'b0;
        check("bp_skid_full", 32'(pr_o[d]), 32'd0);
      end
      for (int c = 0; c < 10; c++) begin
        check("bp_hold_valid", 32'(popv[d]), 32'b0010);
        check("bp_hold_data", 32'(popd[d][1]), 32'h3C);
        if (d == 0) check("bp_push_ready_low", 32'(pr_o[d]), 32'd0);
        tick();
      end
      prdy[d] = 4'b1111;
      tick();
      pv[d] = 1'b0;
      check("bp_second_valid", 32'(popv[d]), 32'b0010);
      check("bp_second_data", 32'(popd[d][1]), 32'h55);
      tick();
      check("bp_drain", 32'(popv[d]), 32'd0);

      prdy[d] = 4'b1110; pv[d] = 1'b1; pd[d] = 8'h11; ps[d] = 2'd0;
      tick();
      if (d == 1) begin
        pd[d] = 8'h12;
        tick();
      end
      pd[d] = 8'h13;
      for (int c = 0; c < 3; c++) begin
        check("hol_push_ready", 32'(pr_o[d]), 32'd0);
        check("hol_pop_valid", 32'(popv[d]), 32'b0001);
        tick();
      end
      prdy[d] = 4'b1111;
      for (k = 0; k < 4; k++) begin
        if (pr_o[d]) break;
        tick();
      end
      check("hol_release", 32'(k < 4), 32'd1);
      tick();
      pv[d] = 1'b0;
      repeat (3) tick();
      check("hol_drain", 32'(popv[d]), 32'd0);

      base = npops[d];
      for (int i = 0; i < 16; i++) begin
        pv[d] = 1'b1; pd[d] = 8'h40 + 8'(i); ps[d] = 2'(i % 4);
        check("tput_push_ready", 32'(pr_o[d]), 32'd1);
        tick();
        check("tput_pop_valid", 32'(popv[d]), 32'(4'b0001 << (i % 4)));
      end
      pv[d] = 1'b0;
      tick();
      check("tput_pop_count", 32'(npops[d] - base), 32'd16);

      prdy[d] = 4'b0000; pv[d] = 1'b1; pd[d] = 8'h99; ps[d] = 2'd3;
      tick();
      pv[d] = 1'b0;
      check("mid_pop_valid", 32'(popv[d]), 32'b1000);
      rst_i[d] = 1'b1;
      for (int l = 0; l < 4; l++) sb[d*4+l].delete();
      tick();
      check("mid_rst_valid", 32'(popv[d]), 32'd0);
      check("mid_rst_data", 32'(popd[d]), 32'd0);
      tick();
      rst_i[d] = 1'b0; prdy[d] = 4'b1111;
      tick();
      check("mid_after_valid", 32'(popv[d]), 32'd0);
    end

    cur_d = 2;
    rst2 = 1'b1;
    tick();
    tick();
    rst2 = 1'b0; ps2 = 2'd3;
    tick();
    check("oor_push_ready", 32'(pr2), 32'd0);
    check("oor_pop_valid", 32'(popv2), 32'd0);
    ps2 = 2'd1;
    #1;
    check("legal_push_ready", 32'(pr2), 32'd1);

    for (int l = 0; l < 8; l++) begin
      check("sb_empty", 32'(sb[l].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_flow_demux_select_stable.md
Name: br_flow_demux_select_stable

Overview:
- Flow-controlled stable demultiplexer: one ready-valid push interface is routed to one of NumFlows ready-valid pop interfaces, chosen by a select index carried with each push beat.
- Each pop interface has its own output register, so pop_valid and pop_data are stable under backpressure.
- Sits directly downstream of the fixed-priority stable flow mux. It takes a mux pop stream plus a destination index and fans it out to per-destination consumers.
- Single-cycle latency from push to pop.

Parameters:
- NumFlows, 2, number of pop flows; must be >= 2.
- Width, 1, data width in bits; must be >= 1.
- RegisterPopReady, 0.
  - 0: each pop lane is a 1-entry forward register, and push_ready depends combinationally on pop_ready.
  - 1: each pop lane is a 2-entry skid register, so there is no combinational path from pop_ready to push_ready.
- EnableCoverPushBackpressure, 1.
  - 1: cover that push_valid is high while push_ready is low.
  - 0: assert that this never happens.
- EnableAssertPushDataKnown, 1: assert that push_data and push_select are not X while push_valid is high.
- EnableAssertFinalNotValid, 1: assert that push_valid and all pop_valid bits are low at end of test.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  synchronous, active-high reset.
- push_ready  output  1  push beat is accepted when push_valid and push_ready are both high.
- push_valid  input  1  push beat present.
- push_data  input  Width  push payload.
- push_select  input  $clog2(NumFlows)  destination pop flow index.
- pop_ready  input  NumFlows  per-flow consumer ready.
- pop_valid  output  NumFlows  per-flow output valid.
- pop_data  output  NumFlows x Width  per-flow output payload.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset: all pop_valid bits = 0 and pop_data = 0 in the cycle after rst is sampled high. Skid entries are cleared. Reset mid-operation discards all buffered beats without producing a pop.
- push_ready:
  - push_ready = lane_ready[push_select].
  - With RegisterPopReady=0: lane_ready[i] = !pop_valid[i] || pop_ready[i].
  - With RegisterPopReady=1: lane_ready[i] = skid entry for lane i is empty (a registered signal).
  - push_ready is low while rst is high.
- Head-of-line blocking: a push to a stalled lane blocks all pushes, even if other lanes are idle. This is intended.
- Out-of-range select: push_select >= NumFlows forces push_ready = 0, and an assertion fires when push_valid is high.
- Latency: a beat accepted in cycle N gives pop_valid[push_select] = 1 in cycle N+1, carrying that push_data.
- Throughput: one beat per cycle when the selected lane drains every cycle.
- Stability:
  - Once pop_valid[i] rises, pop_valid[i] and pop_data[i] hold until pop_ready[i] is sampled high. This is asserted.
  - Lane i updates only when it is empty, or on the same cycle its head is popped (pop and push together in one cycle).
- Skid mode (RegisterPopReady=1):
  - A beat arriving while the lane head is stalled goes into the skid entry.
  - The skid entry moves to the head on the next pop.
  - lane_ready drops while the skid entry is full.
  - Per-lane ordering is preserved.
- Lane independence: pop on one lane never changes the state of another lane.
- Push-side assumptions, checked by assertions:
  - push_valid stays high until accepted.
  - push_data and push_select stay stable while push_valid is high and push_ready is low.
- Static checks: NumFlows >= 2 and Width >= 1.

Test Plan:
- Reset: drive rst=1 for 3 cycles with push_valid=1 -> push_ready=0, all pop_valid=0, pop_data=0; pop_valid stays 0 on the first cycle after reset is released.
- Basic routing: NumFlows=4, Width=8, all pop_ready=1; push 0xA1 to select 2 in cycle 5 -> pop_valid=4'b0100 and pop_data[2]=0xA1 in cycle 6; all other lanes stay idle.
- Backpressure stability: pop_ready[1]=0; push 0x3C to lane 1, then present 0x55 to lane 1.
  - pop_data[1] stays 0x3C for 10 cycles.
  - With RegisterPopReady=0: push_ready=0.
  - With RegisterPopReady=1: 0x55 is accepted into skid, then push_ready=0.
  - After pop_ready[1]=1 the lane outputs 0x3C then 0x55 on consecutive pops.
- Head-of-line blocking: lane 0 stalled and full; push to lane 0 stalled -> lanes 1 to 3 receive nothing until pop_ready[0]=1 releases it, then the lane 0 beat enters.
- Full throughput: 16 back-to-back pushes rotating select 0,1,2,3 with all ready -> 16 pops in 16 consecutive cycles, in order per lane, no bubbles.
- Illegal select: NumFlows=3, push_select=3 with push_valid=1 -> push_ready=0 and the out-of-range assertion fires; no pop_valid rises.
